// File: rtl/lane_sync_tx.sv
// lane_sync_tx: frames a byte stream into a high-speed lane burst (zero preamble, 0xB8 sync, payload, trailer).
// Optional bit skew of the lane stream is compiled in with the macro LANE_TX_SKEW_EN.
module lane_sync_tx #(
  parameter int PREAMBLE_LEN = 4,
  parameter int TRAILER_LEN  = 2,
  parameter int SKEW         = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic [7:0] lane_data,
  output logic       lane_hs_en,
  output logic       err_underrun
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, TRAILER} state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam logic [3:0] PRE_LAST  = 4'(PREAMBLE_LEN - 2);
  localparam logic [3:0] TRL_LAST  = 4'(TRAILER_LEN);

  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_bad_preamble
    $error("PREAMBLE_LEN must be 1..15");
  end
  if (TRAILER_LEN < 1 || TRAILER_LEN > 15) begin : g_bad_trailer
    $error("TRAILER_LEN must be 1..15");
  end
  if (SKEW < 0 || SKEW > 7) begin : g_bad_skew
    $error("SKEW must be 0..7");
  end

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] word, word_nxt;
  logic       hs, hs_nxt;
  logic       err_nxt;
  logic       msb, msb_nxt;
  logic       short_trl, short_nxt;
  logic       start_ok;
  logic [7:0] trail_byte;

  assign trail_byte = {8{~msb}};
  assign byte_ready = (state == DATA);

  // The lane word is loaded on the edge leaving each state cycle, so the entry edge
  // supplies the first preamble zero and the underrun edge supplies the first trailer byte.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word;
    hs_nxt    = hs;
    err_nxt   = 1'b0;
    msb_nxt   = msb;
    short_nxt = short_trl;
    unique case (state)
      IDLE: begin
        word_nxt = 8'h00;
        hs_nxt   = 1'b0;
        if (byte_valid && start_ok) begin
          state_nxt = (PREAMBLE_LEN > 1) ? PREAMBLE : SYNC;
          hs_nxt    = 1'b1;
        end
      end
      PREAMBLE: begin
        word_nxt = 8'h00;
        if (cnt == PRE_LAST) state_nxt = SYNC;
        else                 cnt_nxt   = cnt + 4'd1;
      end
      SYNC: begin
        word_nxt  = SYNC_BYTE;
        msb_nxt   = SYNC_BYTE[7];
        state_nxt = DATA;
      end
      DATA: begin
        if (byte_valid) begin
          word_nxt = byte_data;
          msb_nxt  = byte_data[7];
          if (byte_last) begin
            state_nxt = TRAILER;
            short_nxt = 1'b0;
          end
        end else begin
          word_nxt  = trail_byte;
          err_nxt   = 1'b1;
          short_nxt = 1'b1;
          state_nxt = TRAILER;
        end
      end
      TRAILER: begin
        if (cnt == TRL_LAST - {3'b000, short_trl}) begin
          state_nxt = IDLE;
          word_nxt  = 8'h00;
          hs_nxt    = 1'b0;
        end else begin
          word_nxt = trail_byte;
          cnt_nxt  = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = 4'd0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      word         <= 8'h00;
      hs           <= 1'b0;
      err_underrun <= 1'b0;
      msb          <= 1'b0;
      short_trl    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      word         <= word_nxt;
      hs           <= hs_nxt;
      err_underrun <= err_nxt;
      msb          <= msb_nxt;
      short_trl    <= short_nxt;
    end
  end

`ifdef LANE_TX_SKEW_EN
  if (SKEW == 0) begin : g_no_skew
    assign lane_data  = word;
    assign lane_hs_en = hs;
    assign start_ok   = 1'b1;
  end else begin : g_skew
    logic [7:0] prev;
    logic       hs_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        prev <= 8'h00;
        hs_d <= 1'b0;
      end else begin
        prev <= word;
        hs_d <= hs;
      end
    end

    // The flush cycle keeps hs_en high, so a new burst waits until it has passed.
    assign lane_data  = {word[7-SKEW:0], prev[7:8-SKEW]};
    assign lane_hs_en = hs | hs_d;
    assign start_ok   = ~hs_d;
  end
`else
  assign lane_data  = word;
  assign lane_hs_en = hs;
  assign start_ok   = 1'b1;
`endif

endmodule

// File: tb/tb_lane_sync_tx.sv
// tb_lane_sync_tx: directed and random bursts against a bit-stream reference model of the lane framer.
// Builds with or without LANE_TX_SKEW_EN; the model applies the matching bit delay.
`timescale 1ns/1ps
module tb_lane_sync_tx;

  localparam int PRE = 4;
  localparam int TRL = 2;
`ifdef LANE_TX_SKEW_EN
  localparam int SK = 3;
`else
  localparam int SK = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic [7:0] lane_data;
  logic       lane_hs_en;
  logic       err_underrun;

  lane_sync_tx dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .lane_data   (lane_data),
    .lane_hs_en  (lane_hs_en),
    .err_underrun(err_underrun)
  );

  always #5 sys_clk = ~sys_clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] payload[$];
  logic [7:0] captured[$];

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // Expected wire: PRE zeros, B8, accepted bytes, TRL inverse-msb bytes, serialised LSB first
  // and delayed by SK bits (plus one flush word when skewed), then one idle word.
  task automatic applyStimulus(input string name, input int drop_at, input int rst_at, input bit hold_valid);
    logic [7:0] words[$];
    logic [7:0] exp_lane[$];
    logic       exp_hs[$];
    logic       exp_err[$];
    logic       exp_rdy[$];
    logic       bits[$];
    logic [7:0] w;
    logic       last_msb;
    int         n_pay, err_idx, n_out, idx, rdy_end;

    for (int i = 0; i < PRE; i++) words.push_back(8'h00);
    words.push_back(8'hB8);
    last_msb = 1'b1;
    n_pay = (drop_at >= 0) ? drop_at : payload.size();
    for (int i = 0; i < n_pay; i++) begin
      words.push_back(payload[i]);
      last_msb = payload[i][7];
    end
    err_idx = (drop_at >= 0) ? words.size() : -1;
    rdy_end = PRE + n_pay + ((drop_at >= 0) ? 1 : 0);
    for (int i = 0; i < TRL; i++) words.push_back({8{~last_msb}});

    for (int i = 0; i < SK; i++) bits.push_back(1'b0);
    foreach (words[i]) for (int b = 0; b < 8; b++) bits.push_back(words[i][b]);
    for (int i = 0; i < 8; i++) bits.push_back(1'b0);
    n_out = words.size() + ((SK > 0) ? 1 : 0);
    for (int j = 0; j < n_out; j++) begin
      for (int b = 0; b < 8; b++) w[b] = bits[8*j+b];
      exp_lane.push_back(w);
      exp_hs.push_back(1'b1);
      exp_err.push_back(j == err_idx);
      exp_rdy.push_back(j >= PRE && j < rdy_end);
    end
    exp_lane.push_back(8'h00);
    exp_hs.push_back(1'b0);
    exp_err.push_back(1'b0);
    exp_rdy.push_back(1'b0);

    captured.delete();
    idx = 0;
    for (int c = 0; c < exp_lane.size(); c++) begin
      if (drop_at >= 0 && idx >= drop_at && c > 0) begin
        byte_valid = 1'b0;
        byte_last  = 1'b0;
      end else if (idx < payload.size()) begin
        byte_valid = 1'b1;
        byte_data  = payload[idx];
        byte_last  = (idx == payload.size() - 1);
      end else begin
        byte_valid = hold_valid;
        byte_last  = 1'b0;
      end
      if (rst_at >= 0 && byte_ready && idx == rst_at) begin
        sys_rst = 1'b1;
        #1;
        checkOutput({name, " rst lane"},  lane_data, 8'h00);
        checkOutput({name, " rst hs"},    {7'b0, lane_hs_en}, 8'h00);
        checkOutput({name, " rst err"},   {7'b0, err_underrun}, 8'h00);
        checkOutput({name, " rst ready"}, {7'b0, byte_ready}, 8'h00);
        byte_valid = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        return;
      end
      if (byte_valid && byte_ready) idx++;
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (lane_hs_en) captured.push_back(lane_data);
      checkOutput($sformatf("%s lane c%0d", name, c),  lane_data, exp_lane[c]);
      checkOutput($sformatf("%s hs c%0d", name, c),    {7'b0, lane_hs_en}, {7'b0, exp_hs[c]});
      checkOutput($sformatf("%s err c%0d", name, c),   {7'b0, err_underrun}, {7'b0, exp_err[c]});
      checkOutput($sformatf("%s ready c%0d", name, c), {7'b0, byte_ready}, {7'b0, exp_rdy[c]});
    end
  endtask

  // Receive-side aligner: hunt the sync pattern at any bit offset, then regroup payload bytes.
  task automatic alignCheck(input string name);
    logic       bits[$];
    logic [7:0] w;
    int         pos;
    pos = -1;
    foreach (captured[i]) for (int b = 0; b < 8; b++) bits.push_back(captured[i][b]);
    for (int p = 0; p + 8 <= bits.size() && pos < 0; p++) begin
      for (int b = 0; b < 8; b++) w[b] = bits[p+b];
      if (w == 8'hB8) pos = p;
    end
    checkOutput({name, " align pos"}, 8'(pos), 8'(8*PRE + SK));
    if (pos >= 0) begin
      for (int i = 0; i < payload.size(); i++) begin
        for (int b = 0; b < 8; b++)
          w[b] = (pos + 8*(i+1) + b < bits.size()) ? bits[pos + 8*(i+1) + b] : 1'bx;
        checkOutput($sformatf("%s align byte%0d", name, i), w, payload[i]);
      end
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    repeat (2) @(negedge sys_clk);
    checkOutput("reset lane",  lane_data, 8'h00);
    checkOutput("reset hs",    {7'b0, lane_hs_en}, 8'h00);
    checkOutput("reset err",   {7'b0, err_underrun}, 8'h00);
    checkOutput("reset ready", {7'b0, byte_ready}, 8'h00);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    payload = '{8'h11, 8'h22, 8'h33};
    applyStimulus("burst3", -1, -1, 1'b0);
    checkOutput("burst3 hs cycles", 8'(captured.size()), 8'(PRE + 1 + 3 + TRL + ((SK > 0) ? 1 : 0)));
    alignCheck("burst3");

    payload = '{8'hA5, 8'h7E};
    applyStimulus("trl_ff", -1, -1, 1'b0);
    payload = '{8'h3C, 8'h80};
    applyStimulus("trl_00", -1, -1, 1'b0);

    payload = '{8'h91, 8'h42, 8'h5A, 8'hC3};
    applyStimulus("underrun", 2, -1, 1'b0);

    payload = '{8'h12, 8'h34, 8'h56, 8'h78};
    applyStimulus("reset_mid", -1, 1, 1'b0);
    payload = '{8'h9A, 8'hBC};
    applyStimulus("after_rst", -1, -1, 1'b0);

    payload = '{8'h01, 8'h82};
    applyStimulus("b2b_first", -1, -1, 1'b1);
    payload = '{8'hE7, 8'h18, 8'h66};
    applyStimulus("b2b_second", -1, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int len, drop;
      len = $urandom_range(1, 6);
      payload.delete();
      for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
      drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      applyStimulus($sformatf("rand%0d", r), drop, -1, 1'b0);
      if (drop < 0) alignCheck($sformatf("rand%0d", r));
    end

    repeat (2) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lane_sync_tx.md
LANE_SYNC_TX -- requirements
Module: lane_sync_tx

Interface
REQ-001 SHALL provide parameter PREAMBLE_LEN, default 4, number of HS-zero bytes sent before the sync byte (range 1-15).
REQ-002 SHALL provide parameter TRAILER_LEN, default 2, number of trailer bytes sent after the last payload byte (range 1-15).
REQ-003 SHALL provide parameter SKEW, default 3, bit delay applied to the lane stream when LANE_TX_SKEW_EN is defined (range 0-7).
REQ-004 SHALL have port sys_clk  input  1  sole clock; all logic on the rising edge.
REQ-005 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port byte_data  input  8  payload byte.
REQ-007 SHALL have port byte_valid  input  1  byte_data valid.
REQ-008 SHALL have port byte_last  input  1  marks the final payload byte of a burst.
REQ-009 SHALL have port byte_ready  output  1  block accepts byte_data this cycle.
REQ-010 SHALL have port lane_data  output  8  lane word, LSB transmitted first.
REQ-011 SHALL have port lane_hs_en  output  1  high-speed burst active.
REQ-012 SHALL have port err_underrun  output  1  one-cycle pulse on a payload gap.

Function
REQ-013 SHALL implement FSM states IDLE, PREAMBLE, SYNC, DATA, TRAILER.
REQ-014 IDLE SHALL hold byte_ready=0, lane_hs_en=0, lane_data=8'h00.
REQ-015 In IDLE, byte_valid=1 sampled at an edge SHALL move to PREAMBLE. lane_hs_en=1 and lane_data=8'h00 SHALL be registered on that same edge.
REQ-016 PREAMBLE SHALL output 8'h00 for exactly PREAMBLE_LEN cycles, then SYNC SHALL output 8'hB8 for one cycle.
REQ-017 byte_ready SHALL be 1 only in DATA. It SHALL be combinational from state and not depend on byte_valid.
REQ-018 A transfer SHALL occur on an edge with byte_valid and byte_ready both high. lane_data SHALL take byte_data on that edge, giving 1-cycle latency.
REQ-019 A transfer with byte_last=1 SHALL move to TRAILER.
REQ-020 In DATA, byte_valid=0 SHALL move to TRAILER, pulse err_underrun for one cycle and accept no byte.
REQ-021 TRAILER SHALL output TRAILER_LEN bytes, each with all bits equal to the inverse of bit 7 of the last transmitted word (SYNC counts if no payload was sent). It SHALL then return to IDLE, deasserting lane_hs_en.
REQ-022 The block SHALL re-enter PREAMBLE no earlier than one full IDLE cycle after TRAILER, guaranteeing one lane_hs_en=0 cycle between bursts.
REQ-023 The PREAMBLE/TRAILER counter SHALL be 4 bits, SHALL clear on every state entry, and SHALL NOT wrap.
REQ-024 All outputs except byte_ready SHALL be registered.

Reset
REQ-025 Asserting sys_rst SHALL immediately force IDLE, lane_data=8'h00, lane_hs_en=0, err_underrun=0, counters=0 and the skew history=0.
REQ-026 Reset mid-burst SHALL abort the burst with no trailer; the first burst after release SHALL start with a full preamble.

Configuration
REQ-027 With macro LANE_TX_SKEW_EN defined, lane_data SHALL be the stream delayed by SKEW bits: {cur[7-SKEW:0], prev[7:8-SKEW]}, where prev is the previous unskewed word (8'h00 after IDLE).
REQ-028 With LANE_TX_SKEW_EN defined, lane_hs_en SHALL stay high one extra cycle to flush the residual bits.
REQ-029 With LANE_TX_SKEW_EN defined and SKEW=0, output SHALL be identical to the undefined case.
REQ-030 Without LANE_TX_SKEW_EN, lane_data SHALL be the unskewed word and no skew logic SHALL be present.

Verification
REQ-031 Bench SHALL cover: defaults, burst 11,22,33 with last on 33 -> lane_data 00,00,00,00,B8,11,22,33,FF,FF; hs_en high for exactly 10 cycles.
REQ-032 Bench SHALL cover: burst A5,7E(last) -> trailer bytes FF,FF (7E bit7=0); burst 3C,80(last) -> trailer 00,00.
REQ-033 Bench SHALL cover: byte_valid dropped after 2 of 4 bytes -> err_underrun pulses once, trailer follows, remaining bytes not accepted.
REQ-034 Bench SHALL cover: sys_rst asserted during the second payload byte -> lane_hs_en=0 and lane_data=00 before the next edge; next burst starts with 4x00.
REQ-035 Bench SHALL cover: LANE_TX_SKEW_EN with SKEW=3 fed into the receive byte aligner -> aligner reports alignment and recovers 11,22,33 in order.
REQ-036 Bench SHALL cover: back-to-back bursts with byte_valid held high -> at least one IDLE cycle with lane_hs_en=0 between them.
